dmem_port_ctrl: RTL and testbench

Registered request stage between the load/store queue's unified cache port and the data cache. It latches one LSQ request at a time, holds it stable toward the cache until the cache responds, and returns the response to the LSQ. It also absorbs responses for requests that were in flight when a pipeline flush hit, so the freshly reset LSQ never receives a stale `ufp_resp`.

---
 rtl/dmem_port_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ctrl.sv
// Registered request stage between the LSQ cache port and the data cache.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_port_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] ufp_addr,
    input  logic [3:0]  ufp_rmask,
    input  logic [3:0]  ufp_wmask,
    input  logic [31:0] ufp_wdata,
    output logic [31:0] ufp_rdata,
    output logic        ufp_resp,
    output logic [31:0] dc_addr,
    output logic [3:0]  dc_rmask,
    output logic [3:0]  dc_wmask,
    output logic [31:0] dc_wdata,
    input  logic [31:0] dc_rdata,
    input  logic        dc_resp,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_squashed
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  rmask_q, rmask_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rmask_q <= rmask_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rmask_d   = rmask_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        squash    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (((ufp_rmask | ufp_wmask) != 4'h0) && !flush) begin
                    addr_d  = ufp_addr;
                    // A request carrying both masks is treated as a store.
                    rmask_d = (ufp_wmask != 4'h0) ? 4'h0 : ufp_rmask;
                    wmask_d = ufp_wmask;
                    wdata_d = ufp_wdata;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (dc_resp) begin
                    addr_d  = '0;
                    rmask_d = '0;
                    wmask_d = '0;
                    wdata_d = '0;
                    state_d = StIdle;
                    if (flush) begin
                        squash = 1'b1;
                    end else begin
                        ufp_resp  = 1'b1;
                        ufp_rdata = (wmask_q != 4'h0) ? 32'h0 : dc_rdata;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (dc_resp) begin
                    addr_d  = '0;
                    rmask_d = '0;
                    wmask_d = '0;
                    wdata_d = '0;
                    state_d = StIdle;
                    squash  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign dc_addr  = addr_q;
    assign dc_rmask = rmask_q;
    assign dc_wmask = wmask_q;
    assign dc_wdata = wdata_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] loads_q, stores_q, stalls_q, squashed_q;
    logic        waiting;

    assign waiting = ((state_q == StBusy) || (state_q == StDrain)) && !dc_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q    <= '0;
            stores_q   <= '0;
            stalls_q   <= '0;
            squashed_q <= '0;
        end else begin
            if (ufp_resp && (rmask_q != 4'h0)) loads_q <= loads_q + 32'd1;
            if (ufp_resp && (wmask_q != 4'h0)) stores_q <= stores_q + 32'd1;
            if (waiting) stalls_q <= stalls_q + 32'd1;
            if (squash) squashed_q <= squashed_q + 32'd1;
        end
    end

    assign perf_loads    = loads_q;
    assign perf_stores   = stores_q;
    assign perf_stalls   = stalls_q;
    assign perf_squashed = squashed_q;
`else
    logic unused_squash;
    assign unused_squash = squash;
    assign perf_loads    = '0;
    assign perf_stores   = '0;
    assign perf_stalls   = '0;
    assign perf_squashed = '0;
`endif

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl with a response scoreboard.
module tb_dmem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] ufp_addr = '0;
    logic [3:0]  ufp_rmask = '0;
    logic [3:0]  ufp_wmask = '0;
    logic [31:0] ufp_wdata = '0;
    logic [31:0] ufp_rdata;
    logic        ufp_resp;
    logic [31:0] dc_addr;
    logic [3:0]  dc_rmask;
    logic [3:0]  dc_wmask;
    logic [31:0] dc_wdata;
    logic [31:0] dc_rdata = '0;
    logic        dc_resp = 1'b0;
    logic [31:0] perf_loads, perf_stores, perf_stalls, perf_squashed;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef DMEM_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    dmem_port_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ufp_addr     (ufp_addr),
        .ufp_rmask    (ufp_rmask),
        .ufp_wmask    (ufp_wmask),
        .ufp_wdata    (ufp_wdata),
        .ufp_rdata    (ufp_rdata),
        .ufp_resp     (ufp_resp),
        .dc_addr      (dc_addr),
        .dc_rmask     (dc_rmask),
        .dc_wmask     (dc_wmask),
        .dc_wdata     (dc_wdata),
        .dc_rdata     (dc_rdata),
        .dc_resp      (dc_resp),
        .perf_loads   (perf_loads),
        .perf_stores  (perf_stores),
        .perf_stalls  (perf_stalls),
        .perf_squashed(perf_squashed)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pe(input logic [31:0] v);
        return PerfEn ? v : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] l, input logic [31:0] s,
                            input logic [31:0] st, input logic [31:0] sq);
        chk({tag, "_loads"}, perf_loads, pe(l));
        chk({tag, "_stores"}, perf_stores, pe(s));
        chk({tag, "_stalls"}, perf_stalls, pe(st));
        chk({tag, "_squashed"}, perf_squashed, pe(sq));
    endtask

    // Scoreboard: every ufp_resp must match the oldest expected read data.
    always @(negedge clk) begin
        if (!rst && ufp_resp) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed resp rdata %h expected no resp", ufp_rdata);
            end else begin
                chk("sb_rdata", ufp_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        tick(); tick();
        settle();
        chk("rst_dc_addr", dc_addr, 32'h0);
        chk("rst_dc_rmask", {28'h0, dc_rmask}, 32'h0);
        chk("rst_dc_wmask", {28'h0, dc_wmask}, 32'h0);
        chk("rst_dc_wdata", dc_wdata, 32'h0);
        chk("rst_ufp_resp", {31'h0, ufp_resp}, 32'h0);
        chk("rst_ufp_rdata", ufp_rdata, 32'h0);
        chk_perf("rst", 0, 0, 0, 0);
        rst = 1'b0;

        // Single load, three-cycle round trip
        tick();
        ufp_addr = 32'h1000; ufp_rmask = 4'hF;
        exp_q.push_back(32'hDEADBEEF);
        tick(); settle();
        chk("ld_dc_addr", dc_addr, 32'h1000);
        chk("ld_dc_rmask", {28'h0, dc_rmask}, 32'hF);
        chk("ld_dc_wmask", {28'h0, dc_wmask}, 32'h0);
        tick(); settle();
        chk("ld_wait_resp", {31'h0, ufp_resp}, 32'h0);
        tick();
        dc_resp = 1'b1; dc_rdata = 32'hDEADBEEF; ufp_rmask = 4'h0;
        settle();
        chk("ld_resp", {31'h0, ufp_resp}, 32'h1);
        chk("ld_rdata", ufp_rdata, 32'hDEADBEEF);
        tick();
        dc_resp = 1'b0;
        settle();
        chk("ld_clear_rmask", {28'h0, dc_rmask}, 32'h0);
        chk_perf("ld", 1, 0, 2, 0);

        // Back-to-back store then load
        ufp_addr = 32'h2000; ufp_wmask = 4'h3; ufp_wdata = 32'h1234;
        exp_q.push_back(32'h0);
        tick(); settle();
        chk("st_dc_addr", dc_addr, 32'h2000);
        chk("st_dc_wmask", {28'h0, dc_wmask}, 32'h3);
        chk("st_dc_wdata", dc_wdata, 32'h1234);
        chk("st_dc_rmask", {28'h0, dc_rmask}, 32'h0);
        tick();
        dc_resp = 1'b1; dc_rdata = 32'hAAAA5555;
        ufp_addr = 32'h2004; ufp_wmask = 4'h0; ufp_rmask = 4'hF; ufp_wdata = 32'h0;
        exp_q.push_back(32'h600DF00D);
        settle();
        chk("st_resp", {31'h0, ufp_resp}, 32'h1);
        chk("st_rdata_zero", ufp_rdata, 32'h0);
        tick();
        dc_resp = 1'b0;
        settle();
        chk("b2b_gap_addr", dc_addr, 32'h0);
        chk("b2b_gap_wmask", {28'h0, dc_wmask}, 32'h0);
        tick(); settle();
        chk("b2b_ld_addr", dc_addr, 32'h2004);
        chk("b2b_ld_rmask", {28'h0, dc_rmask}, 32'hF);
        tick();
        dc_resp = 1'b1; dc_rdata = 32'h600DF00D; ufp_rmask = 4'h0;
        settle();
        chk("b2b_ld_resp", {31'h0, ufp_resp}, 32'h1);
        tick();
        dc_resp = 1'b0;
        settle();
        chk_perf("b2b", 2, 1, 4, 0);

        // Flush while a load is outstanding, then drain
        ufp_addr = 32'h3000; ufp_rmask = 4'h1;
        tick(); settle();
        chk("fl_dc_rmask", {28'h0, dc_rmask}, 32'h1);
        tick();
        flush = 1'b1; ufp_rmask = 4'h0;
        tick();
        flush = 1'b0; ufp_addr = 32'h4000; ufp_rmask = 4'hF;
        exp_q.push_back(32'h44444444);
        settle();
        chk("fl_drain_hold", {28'h0, dc_rmask}, 32'h1);
        tick();
        flush = 1'b1;
        settle();
        chk("fl_drain_addr", dc_addr, 32'h3000);
        chk("fl_drain_noresp", {31'h0, ufp_resp}, 32'h0);
        tick();
        flush = 1'b0; dc_resp = 1'b1; dc_rdata = 32'h00000BAD;
        settle();
        chk("fl_squash_resp", {31'h0, ufp_resp}, 32'h0);
        chk("fl_squash_hold", {28'h0, dc_rmask}, 32'h1);
        tick();
        dc_resp = 1'b0;
        settle();
        chk("fl_idle_clear", {28'h0, dc_rmask}, 32'h0);
        tick(); settle();
        chk("fl_next_addr", dc_addr, 32'h4000);
        tick();
        dc_resp = 1'b1; dc_rdata = 32'h44444444; ufp_rmask = 4'h0;
        settle();
        chk("fl_next_resp", {31'h0, ufp_resp}, 32'h1);
        tick();
        dc_resp = 1'b0;
        settle();
        chk_perf("fl", 3, 1, 9, 1);

        // Flush coincident with dc_resp, then a both-masks request
        ufp_addr = 32'h5000; ufp_rmask = 4'hF;
        tick(); settle();
        chk("fr_dc_addr", dc_addr, 32'h5000);
        tick();
        flush = 1'b1; dc_resp = 1'b1; dc_rdata = 32'h5555; ufp_rmask = 4'h0;
        settle();
        chk("fr_noresp", {31'h0, ufp_resp}, 32'h0);
        tick();
        flush = 1'b0; dc_resp = 1'b0;
        ufp_addr = 32'h6000; ufp_rmask = 4'hF; ufp_wmask = 4'hF; ufp_wdata = 32'hCAFE;
        exp_q.push_back(32'h0);
        settle();
        chk("fr_idle_addr", dc_addr, 32'h0);
        tick(); settle();
        chk("both_addr", dc_addr, 32'h6000);
        chk("both_wmask", {28'h0, dc_wmask}, 32'hF);
        chk("both_rmask", {28'h0, dc_rmask}, 32'h0);
        chk("both_wdata", dc_wdata, 32'hCAFE);
        tick();
        dc_resp = 1'b1; dc_rdata = 32'h77; ufp_rmask = 4'h0; ufp_wmask = 4'h0;
        settle();
        chk("both_resp", {31'h0, ufp_resp}, 32'h1);
        tick();
        dc_resp = 1'b0;

        // Request presented with flush in IDLE is dropped
        ufp_addr = 32'h7000; ufp_rmask = 4'hF; flush = 1'b1;
        tick();
        flush = 1'b0; ufp_rmask = 4'h0;
        settle();
        chk("idle_flush_rmask", {28'h0, dc_rmask}, 32'h0);
        chk("idle_flush_addr", dc_addr, 32'h0);
        tick(); settle();
        chk("idle_flush_stay", {28'h0, dc_rmask}, 32'h0);
        chk_perf("mid", 3, 2, 11, 2);

        // Reset while BUSY
        ufp_addr = 32'h8000; ufp_rmask = 4'hF;
        tick(); settle();
        chk("rb_dc_rmask", {28'h0, dc_rmask}, 32'hF);
        rst = 1'b1; ufp_rmask = 4'h0;
        tick();
        rst = 1'b0;
        settle();
        chk("rb_dc_addr", dc_addr, 32'h0);
        chk("rb_dc_rmask", {28'h0, dc_rmask}, 32'h0);
        chk("rb_ufp_resp", {31'h0, ufp_resp}, 32'h0);
        chk_perf("rb", 0, 0, 0, 0);
        ufp_addr = 32'h9000; ufp_rmask = 4'h2;
        exp_q.push_back(32'h99);
        tick(); settle();
        chk("rb_idle_latch", dc_addr, 32'h9000);
        tick();
        dc_resp = 1'b1; dc_rdata = 32'h99; ufp_rmask = 4'h0;
        settle();
        chk("rb_resp", {31'h0, ufp_resp}, 32'h1);
        tick();
        dc_resp = 1'b0;
        settle();
        chk_perf("end", 1, 0, 1, 0);

        tick();
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
